// File: rtl/sync_fifo_if.sv
// Handshake bundle between a sync_fifo and its producer/consumer.
// The master side pushes and pops; the slave side is the FIFO.
interface sync_fifo_if #(
    parameter int data_size  = 8,
    parameter int depth_log2 = 3
);
    logic                  wr_en;
    logic [data_size-1:0]  wr_data;
    logic                  rd_en;
    logic [data_size-1:0]  rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic [depth_log2:0]   count;
    logic                  wr_error;
    logic                  rd_error;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, count, wr_error, rd_error
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, count, wr_error, rd_error
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered read port, occupancy counter and
// one-cycle error pulses for writes while full / reads while empty.
module sync_fifo #(
    parameter int data_size  = 8,
    parameter int depth_log2 = 3
) (
    input logic        clock,
    input logic        reset,
    sync_fifo_if.slave bus
);
    localparam int depth = 1 << depth_log2;
    localparam logic [depth_log2:0]   count_max = (depth_log2 + 1)'(depth);
    localparam logic [depth_log2:0]   count_one = (depth_log2 + 1)'(1);
    localparam logic [depth_log2-1:0] ptr_one   = depth_log2'(1);

    logic [data_size-1:0]  mem_q [depth];
    logic [depth_log2-1:0] wr_ptr_q, wr_ptr_d;
    logic [depth_log2-1:0] rd_ptr_q, rd_ptr_d;
    logic [depth_log2:0]   count_q, count_d;
    logic [data_size-1:0]  rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  wr_error_q, wr_error_d;
    logic                  rd_error_q, rd_error_d;
    logic                  full, empty;
    logic                  wr_accept, rd_accept;

    always_comb begin
        full       = (count_q == count_max);
        empty      = (count_q == '0);
        wr_accept  = bus.wr_en && !full;
        rd_accept  = bus.rd_en && !empty;

        wr_ptr_d   = wr_accept ? wr_ptr_q + ptr_one : wr_ptr_q;
        rd_ptr_d   = rd_accept ? rd_ptr_q + ptr_one : rd_ptr_q;
        rd_data_d  = rd_accept ? mem_q[rd_ptr_q] : rd_data_q;
        rd_valid_d = rd_accept;
        wr_error_d = bus.wr_en && full;
        rd_error_d = bus.rd_en && empty;

        // Simultaneous accepted read and write leave occupancy unchanged.
        count_d = count_q;
        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + count_one;
            2'b01:   count_d = count_q - count_one;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_error_q <= 1'b0;
            rd_error_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            wr_error_q <= wr_error_d;
            rd_error_q <= rd_error_d;
        end
    end

    // Storage is never cleared; a write coinciding with reset is dropped.
    always_ff @(posedge clock) begin
        if (!reset && wr_accept) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.count    = count_q;
    assign bus.wr_error = wr_error_q;
    assign bus.rd_error = rd_error_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: directed vector table for the corner cases, then
// random traffic compared against a queue model of the FIFO.
module tb_sync_fifo;
    localparam int DW = 8;
    localparam int DL = 3;
    localparam int DEPTH = 1 << DL;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    sync_fifo_if #(.data_size(DW), .depth_log2(DL)) bus ();

    sync_fifo #(.data_size(DW), .depth_log2(DL)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        string          name;
        logic           rst;
        logic           we;
        logic [DW-1:0]  wd;
        logic           re;
        int             cnt;
        logic           rv;
        logic [DW-1:0]  rd;
        logic           werr;
        logic           rerr;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic add(input string name, input logic rst, input logic we,
                       input logic [DW-1:0] wd, input logic re, input int cnt,
                       input logic rv, input logic [DW-1:0] rd,
                       input logic werr, input logic rerr);
        vec_t v;
        v.name = name; v.rst = rst; v.we = we; v.wd = wd; v.re = re;
        v.cnt = cnt; v.rv = rv; v.rd = rd; v.werr = werr; v.rerr = rerr;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic we, input logic [DW-1:0] wd,
                         input logic re);
        @(negedge clock);
        reset       = rst;
        bus.wr_en   = we;
        bus.wr_data = wd;
        bus.rd_en   = re;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int cnt, input logic rv,
                         input logic [DW-1:0] rd, input logic werr, input logic rerr);
        logic [DL:0] ecnt;
        logic [DL+DW+5:0] exp_v, act_v;
        ecnt  = (DL + 1)'(cnt);
        exp_v = {ecnt, cnt == DEPTH, cnt == 0, rv, rd, werr, rerr};
        act_v = {bus.count, bus.full, bus.empty, bus.rd_valid, bus.rd_data,
                 bus.wr_error, bus.rd_error};
        n_vec++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s #%0d: got cnt=%0d full=%b empty=%b rv=%b rd=%h werr=%b rerr=%b, want cnt=%0d full=%b empty=%b rv=%b rd=%h werr=%b rerr=%b",
                     name, n_vec, bus.count, bus.full, bus.empty, bus.rd_valid,
                     bus.rd_data, bus.wr_error, bus.rd_error, cnt, cnt == DEPTH,
                     cnt == 0, rv, rd, werr, rerr);
        end
    endtask

    initial begin
        logic [DW-1:0] q[$];
        logic [DW-1:0] m_rd;
        logic          m_rv, m_werr, m_rerr;
        logic          r_rst, r_we, r_re;
        logic [DW-1:0] r_wd;

        bus.wr_en = 1'b0; bus.wr_data = '0; bus.rd_en = 1'b0;

        // reset and idle
        add("reset", 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 2; i++) add("idle", 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        // fill to full, then overflow attempt
        for (int i = 0; i < 8; i++) add("fill", 0, 1, 8'h11 + 8'(i), 0, i + 1, 0, 8'h00, 0, 0);
        add("overflow", 0, 1, 8'h99, 0, 8, 0, 8'h00, 1, 0);
        add("ovf_clear", 0, 0, 8'h00, 0, 8, 0, 8'h00, 0, 0);
        // drain in order, then underflow attempt
        for (int i = 0; i < 8; i++) add("drain", 0, 0, 8'h00, 1, 7 - i, 1, 8'h11 + 8'(i), 0, 0);
        add("underflow", 0, 0, 8'h00, 1, 0, 0, 8'h18, 0, 1);
        // steady state read+write across pointer wrap
        for (int i = 0; i < 4; i++) add("prefill", 0, 1, 8'h20 + 8'(i), 0, i + 1, 0, 8'h18, 0, 0);
        for (int i = 0; i < 20; i++) add("stream", 0, 1, 8'h24 + 8'(i), 1, 4, 1, 8'h20 + 8'(i), 0, 0);
        for (int i = 0; i < 4; i++) add("stream_drain", 0, 0, 8'h00, 1, 3 - i, 1, 8'h34 + 8'(i), 0, 0);
        // both enables while empty, then while full
        add("both_empty", 0, 1, 8'h5A, 1, 1, 0, 8'h37, 0, 1);
        for (int i = 0; i < 7; i++) add("refill", 0, 1, 8'h60 + 8'(i), 0, i + 2, 0, 8'h37, 0, 0);
        add("both_full", 0, 1, 8'hEE, 1, 7, 1, 8'h5A, 1, 0);
        for (int i = 0; i < 7; i++) add("drain2", 0, 0, 8'h00, 1, 6 - i, 1, 8'h60 + 8'(i), 0, 0);
        // reset mid-stream with both enables
        for (int i = 0; i < 5; i++) add("push5", 0, 1, 8'h70 + 8'(i), 0, i + 1, 0, 8'h66, 0, 0);
        add("reset_mid", 1, 1, 8'hAB, 1, 0, 0, 8'h00, 0, 0);
        add("post_reset_rd", 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 1);
        add("post_reset_wr", 0, 1, 8'hC3, 0, 1, 0, 8'h00, 0, 0);
        add("post_reset_rd2", 0, 0, 8'h00, 1, 0, 1, 8'hC3, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].wd, vecs[i].re);
            check(vecs[i].name, vecs[i].cnt, vecs[i].rv, vecs[i].rd,
                  vecs[i].werr, vecs[i].rerr);
        end

        // random traffic against a queue model
        q.delete();
        m_rd = '0; m_rv = 0; m_werr = 0; m_rerr = 0;
        for (int c = 0; c < 1000; c++) begin
            r_rst = (c == 0) || ($urandom_range(0, 49) == 0);
            r_we  = ($urandom_range(0, 9) < 6);
            r_re  = ($urandom_range(0, 9) < 5);
            r_wd  = DW'($urandom);
            if (r_rst) begin
                q.delete();
                m_rd = '0; m_rv = 0; m_werr = 0; m_rerr = 0;
            end else begin
                m_werr = r_we && (q.size() == DEPTH);
                m_rerr = r_re && (q.size() == 0);
                m_rv   = 0;
                if (r_re && q.size() != 0) begin
                    m_rd = q.pop_front();
                    m_rv = 1;
                end
                if (r_we && !m_werr) q.push_back(r_wd);
            end
            drive(r_rst, r_we, r_wd, r_re);
            check("random", q.size(), m_rv, m_rd, m_werr, m_rerr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
